debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_sync.sv | 110 +++++++++++
 tb/tb_debounce_sync.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/debounce_sync.sv
// rtl/debounce_sync.sv - two-flop synchronizer plus four-state debounce FSM; optional glitch counter under DEBOUNCE_GLITCH_CNT_EN
module debounce_sync #(
    parameter int DELAY = 270000,
    parameter int CNT_W = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in,
    output logic       out
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] CHECK_HIGH  = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] CHECK_LOW   = 2'd3;

    // Final count value before a new level is accepted; DELAY=1 accepts on the first check sample.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY - 1);

    logic             sync1;
    logic             sync2;
    logic [1:0]       state;
    logic [CNT_W-1:0] count;

    // Two-flop synchronizer; only sync2 is consumed by the FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: a new level must be seen DELAY consecutive times in a check state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= STABLE_LOW;
            count <= '0;
            out   <= 1'b0;
        end else begin
            case (state)
                STABLE_LOW: begin
                    out <= 1'b0;
                    if (sync2) begin
                        state <= CHECK_HIGH;
                        count <= '0;
                    end
                end
                CHECK_HIGH: begin
                    if (!sync2) begin
                        state <= STABLE_LOW;
                        out   <= 1'b0;
                    end else if (count == LAST) begin
                        state <= STABLE_HIGH;
                        out   <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                        out   <= 1'b0;
                    end
                end
                STABLE_HIGH: begin
                    out <= 1'b1;
                    if (!sync2) begin
                        state <= CHECK_LOW;
                        count <= '0;
                    end
                end
                default: begin
                    if (sync2) begin
                        state <= STABLE_HIGH;
                        out   <= 1'b1;
                    end else if (count == LAST) begin
                        state <= STABLE_LOW;
                        out   <= 1'b0;
                    end else begin
                        count <= count + CNT_W'(1);
                        out   <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic abort;

    // An opposite-level sample while checking means the candidate transition was rejected.
    always_comb begin
        abort = 1'b0;
        if (state == CHECK_HIGH && !sync2) abort = 1'b1;
        if (state == CHECK_LOW  &&  sync2) abort = 1'b1;
    end

    // Saturating count of rejected transitions.
    always_ff @(posedge clock) begin
        if (reset) begin
            glitch_count <= 8'd0;
        end else if (abort && glitch_count != 8'hFF) begin
            glitch_count <= glitch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// tb/tb_debounce_sync.sv - directed self-checking bench for debounce_sync (DELAY=4, CNT_W=4)
module tb_debounce_sync;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in    = 1'b0;
    logic       out;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic saw_high;

    debounce_sync #(.DELAY(4), .CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .in           (in),
        .out          (out)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_count (glitch_count)
`endif
    );

    always #5 clock = ~clock;

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_glitch(input string tag, input logic [7:0] exp);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check(tag, glitch_count, exp);
`else
        if (exp === 8'hxx) $display("unreachable");
`endif
    endtask

    // Input level was just changed: out holds old through E0..E5 and flips on E6.
    task automatic expect_change(input string tag, input logic old_v, input logic new_v);
        for (int k = 0; k < 6; k++) begin
            tick(1);
            check($sformatf("%s_hold_e%0d", tag, k), {7'd0, out}, {7'd0, old_v});
        end
        tick(1);
        check($sformatf("%s_flip_e6", tag), {7'd0, out}, {7'd0, new_v});
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        in    = 1'b0;
        tick(2);
        check("reset_out", {7'd0, out}, 8'd0);
        check_glitch("reset_glitch", 8'd0);
        reset = 1'b0;
        tick(3);
        check("idle_out", {7'd0, out}, 8'd0);

        // Clean rise
        in = 1'b1;
        expect_change("rise", 1'b0, 1'b1);
        check_glitch("rise_glitch", 8'd0);
        tick(5);
        check("rise_hold", {7'd0, out}, 8'd1);

        // One-sample low glitch while high
        in = 1'b0;
        tick(1);
        in = 1'b1;
        saw_high = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (out !== 1'b1) saw_high = 1'b0;
        end
        check("low_glitch_out", {7'd0, saw_high}, 8'd1);
        check_glitch("low_glitch_cnt", 8'd1);

        // Clean fall
        in = 1'b0;
        expect_change("fall", 1'b1, 1'b0);
        check_glitch("fall_glitch", 8'd1);

        // Bounce: high 3 samples, low 1, then high held
        in = 1'b1;
        tick(3);
        check("bounce_mid_out", {7'd0, out}, 8'd0);
        in = 1'b0;
        tick(1);
        in = 1'b1;
        expect_change("bounce", 1'b0, 1'b1);
        check_glitch("bounce_glitch", 8'd2);

        // Reset while in STABLE_HIGH with in held high
        tick(3);
        reset = 1'b1;
        tick(1);
        check("rst_sh_out", {7'd0, out}, 8'd0);
        check_glitch("rst_sh_glitch", 8'd0);
        reset = 1'b0;
        expect_change("rst_sh_requal", 1'b0, 1'b1);

        // Reset while in CHECK_HIGH
        in = 1'b0;
        expect_change("fall2", 1'b1, 1'b0);
        in = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(1);
        check("rst_ch_out", {7'd0, out}, 8'd0);
        check_glitch("rst_ch_glitch", 8'd0);
        reset = 1'b0;
        expect_change("rst_ch_requal", 1'b0, 1'b1);

        // Saturation: 300 single-cycle high pulses from a low level
        in = 1'b0;
        expect_change("fall3", 1'b1, 1'b0);
        saw_high = 1'b0;
        for (int p = 0; p < 300; p++) begin
            in = 1'b1;
            tick(1);
            if (out !== 1'b0) saw_high = 1'b1;
            in = 1'b0;
            tick(1);
            if (out !== 1'b0) saw_high = 1'b1;
        end
        tick(4);
        if (out !== 1'b0) saw_high = 1'b1;
        check("sat_out_never_rose", {7'd0, saw_high}, 8'd0);
        check_glitch("sat_glitch", 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
